legv8_multicycle_sequencer: RTL and testbench



---
 rtl/legv8_ctrl_pkg.sv | 114 +++++++++++
 rtl/legv8_class_decode.sv | 193 +++++++++++++++++++
 rtl/legv8_multicycle_sequencer.sv | 113 +++++++++++
 tb/tb_legv8_multicycle_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// LEGv8 multicycle sequencer shared definitions: control-word layout,
// select encodings, instruction classes and FSM states.
package legv8_ctrl_pkg;

  localparam int CW_W = 34;

  localparam int CW_DA    = 0;
  localparam int CW_SA    = 5;
  localparam int CW_SB    = 10;
  localparam int CW_FS    = 15;
  localparam int CW_PS    = 20;
  localparam int CW_RW    = 22;
  localparam int CW_SIZE  = 23;
  localparam int CW_MW    = 25;
  localparam int CW_MR    = 26;
  localparam int CW_BSEL  = 27;
  localparam int CW_PCSEL = 28;
  localparam int CW_AS    = 29;
  localparam int CW_DS    = 30;
  localparam int CW_IL    = 32;
  localparam int CW_SL    = 33;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BUS  = 2'b10;
  localparam logic [1:0] PS_ADD  = 2'b11;

  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ORR   = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_EOR   = 5'b01100;
  localparam logic [4:0] FS_PASSA = 5'b10000;
  localparam logic [4:0] FS_PASSB = 5'b10100;
  localparam logic [4:0] FS_MOVK  = 5'b11000;
  localparam logic [4:0] FS_MUL   = 5'b11100;

  localparam logic [1:0] DS_ALU = 2'b00;
  localparam logic [1:0] DS_MEM = 2'b01;
  localparam logic [1:0] DS_PC  = 2'b10;

  localparam logic [2:0] CS_ZF12    = 3'd0;
  localparam logic [2:0] CS_ZF16    = 3'd2;
  localparam logic [2:0] CS_MOVMASK = 3'd3;
  localparam logic [2:0] CS_SE26    = 3'd4;
  localparam logic [2:0] CS_SE19    = 3'd5;
  localparam logic [2:0] CS_SE9     = 3'd6;

  typedef struct packed {
    logic       sl;
    logic       il;
    logic [1:0] ds;
    logic       asel;
    logic       pcsel;
    logic       bsel;
    logic       mr;
    logic       mw;
    logic [1:0] size;
    logic       rw;
    logic [1:0] ps;
    logic [4:0] fs;
    logic [4:0] sb;
    logic [4:0] sa;
    logic [4:0] da;
  } cw_t;

  typedef enum logic [2:0] {
    CLS_DIMM,
    CLS_BR,
    CLS_MEM,
    CLS_DREG,
    CLS_ILL
  } cls_e;

  typedef enum logic [1:0] {
    ST_IF,
    ST_EX,
    ST_HALT
  } state_e;

  // flags is {V,C,N,Z}; odd codes below 14 invert the base test
  function automatic logic cond_ok(
    input logic [3:0] c,
    input logic [3:0] flags
  );
    logic v, cf, n, z, r;
    v  = flags[3];
    cf = flags[2];
    n  = flags[1];
    z  = flags[0];
    unique case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cf;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cf & ~z;
      3'd5:    r = (n == v);
      3'd6:    r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    return ((c[3:1] != 3'b111) && c[0]) ? ~r : r;
  endfunction

  function automatic logic [4:0] fs_logic(input logic [1:0] opc);
    logic [4:0] f;
    unique case (opc)
      2'b01:   f = FS_ORR;
      2'b10:   f = FS_EOR;
      default: f = FS_AND;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/legv8_class_decode.sv
// Instruction class, step count and per-step control word lookup.
// MUL decode only exists when LEGV8_SEQ_MUL_EN is defined.
module legv8_class_decode
  import legv8_ctrl_pkg::*;
#(
  parameter int NUM_EX_STATES = 4,
  parameter int MUL_LATENCY   = 3
) (
  input  logic [31:0] i_instr,
  input  logic [4:0]  i_status,
  input  logic [2:0]  i_step,
  output cls_e        o_cls,
  output logic [3:0]  o_steps,
  output logic        o_ill,
  output cw_t         o_cw,
  output logic [2:0]  o_const_sel
);

  logic [3:0] w_op;
  logic [4:0] w_rd, w_rn, w_rm;
  logic       w_dimm, w_br, w_mem, w_dreg;
  logic       w_imm_ar, w_imm_lg, w_imm_mov;
  logic       w_b, w_bl, w_bc, w_cb, w_brr;
  logic       w_ldur, w_stur;
  logic       w_r_ar, w_r_lg, w_mul;
  logic       w_dimm_ok, w_br_ok, w_mem_ok, w_dreg_ok;
  logic       w_unused;
  cls_e       w_cls;
  logic [3:0] w_n;
  cw_t        w_cw;
  logic [2:0] w_cs;

  assign w_op = i_instr[28:25];
  assign w_rd = i_instr[4:0];
  assign w_rn = i_instr[9:5];
  assign w_rm = i_instr[20:16];

  assign w_dimm = (w_op[3:1] == 3'b100);
  assign w_br   = (w_op[3:1] == 3'b101);
  assign w_mem  = w_op[2] & ~w_op[0];
  assign w_dreg = (w_op[2:0] == 3'b101);

  assign w_imm_ar  = (i_instr[25:23] == 3'b010);
  assign w_imm_lg  = (i_instr[25:23] == 3'b100);
  assign w_imm_mov = (i_instr[25:23] == 3'b101) & i_instr[30];

  assign w_b   = (i_instr[31:26] == 6'b000101);
  assign w_bl  = (i_instr[31:26] == 6'b100101);
  assign w_bc  = (i_instr[31:24] == 8'b01010100) & ~i_instr[4];
  assign w_cb  = (i_instr[31:25] == 7'b1011010);
  assign w_brr = (i_instr[31:21] == 11'b11010110000);

  assign w_ldur = (i_instr[31:21] == 11'b11111000010);
  assign w_stur = (i_instr[31:21] == 11'b11111000000);

  assign w_r_lg = (i_instr[28:24] == 5'b01010) & ~i_instr[21];
  assign w_r_ar = (i_instr[28:24] == 5'b01011) & ~i_instr[21];
`ifdef LEGV8_SEQ_MUL_EN
  assign w_mul = (i_instr[28:21] == 8'b11011000);
`else
  assign w_mul = 1'b0;
`endif

  assign w_dimm_ok = w_dimm & (w_imm_ar | w_imm_lg | w_imm_mov);
  assign w_br_ok   = w_br & (w_b | w_bl | w_bc | w_cb | w_brr);
  assign w_mem_ok  = w_mem & (w_ldur | w_stur);
  assign w_dreg_ok = w_dreg & (w_mul | w_r_ar | w_r_lg);

  // shift/amount bits go straight to the datapath, not to control
  assign w_unused = ^i_instr[15:10];

  // class lookup and control word for the current step
  always_comb begin
    w_cls = CLS_ILL;
    w_n   = 4'd1;
    w_cw  = '0;
    w_cs  = CS_ZF12;
    unique case (1'b1)
      w_dimm_ok: begin
        w_cls     = CLS_DIMM;
        w_cw.rw   = 1'b1;
        w_cw.bsel = 1'b1;
        w_cw.da   = w_rd;
        w_cw.sa   = w_rn;
        unique case (1'b1)
          w_imm_ar: begin
            w_cw.fs = i_instr[30] ? FS_SUB : FS_ADD;
            w_cw.sl = i_instr[29];
          end
          w_imm_lg: begin
            w_cw.fs = fs_logic(i_instr[30:29]);
            w_cw.sl = &i_instr[30:29];
          end
          default: begin
            w_cw.sa = w_rd;
            w_cw.fs = i_instr[29] ? FS_MOVK : FS_PASSB;
            w_cs    = i_instr[29] ? CS_MOVMASK : CS_ZF16;
          end
        endcase
      end
      w_br_ok: begin
        w_cls      = CLS_BR;
        w_cw.pcsel = 1'b1;
        unique case (1'b1)
          w_bl: begin
            w_n = 4'd2;
            if (i_step == 3'd0) begin
              w_cw.pcsel = 1'b0;
              w_cw.rw    = 1'b1;
              w_cw.da    = 5'd30;
              w_cw.ds    = DS_PC;
            end else begin
              w_cw.ps = PS_ADD;
              w_cs    = CS_SE26;
            end
          end
          w_b: begin
            w_cw.ps = PS_ADD;
            w_cs    = CS_SE26;
          end
          w_bc: begin
            w_cw.ps = cond_ok(i_instr[3:0], i_status[4:1])
                      ? PS_ADD : PS_HOLD;
            w_cs    = CS_SE19;
          end
          w_cb: begin
            w_cw.sa = w_rd;
            w_cw.fs = FS_PASSA;
            w_cw.ps = (i_instr[24] ^ i_status[0]) ? PS_ADD : PS_HOLD;
            w_cs    = CS_SE19;
          end
          default: begin
            w_cw.pcsel = 1'b0;
            w_cw.sa    = w_rn;
            w_cw.fs    = FS_PASSA;
            w_cw.ps    = PS_BUS;
          end
        endcase
      end
      w_mem_ok: begin
        w_cls     = CLS_MEM;
        w_cw.bsel = 1'b1;
        w_cw.sa   = w_rn;
        w_cw.fs   = FS_ADD;
        w_cw.size = 2'b11;
        w_cs      = CS_SE9;
        if (w_ldur) begin
          w_cw.mr = 1'b1;
          w_cw.rw = 1'b1;
          w_cw.da = w_rd;
          w_cw.ds = DS_MEM;
        end else begin
          w_cw.mw = 1'b1;
          w_cw.sb = w_rd;
        end
      end
      w_dreg_ok: begin
        w_cls   = CLS_DREG;
        w_cw.da = w_rd;
        w_cw.sa = w_rn;
        w_cw.sb = w_rm;
        unique case (1'b1)
          w_mul: begin
            w_n     = 4'(MUL_LATENCY);
            w_cw.fs = FS_MUL;
            w_cw.rw = (i_step == 3'(MUL_LATENCY - 1));
          end
          w_r_ar: begin
            w_cw.rw = 1'b1;
            w_cw.fs = i_instr[30] ? FS_SUB : FS_ADD;
            w_cw.sl = i_instr[29];
          end
          default: begin
            w_cw.rw = 1'b1;
            w_cw.fs = fs_logic(i_instr[30:29]);
            w_cw.sl = &i_instr[30:29];
          end
        endcase
      end
      default: begin
        w_cls = CLS_ILL;
      end
    endcase
  end

  assign o_cls       = w_cls;
  assign o_steps     = w_n;
  assign o_ill       = (w_cls == CLS_ILL) ||
                       (w_n > 4'(NUM_EX_STATES));
  assign o_cw        = w_cw;
  assign o_const_sel = w_cs;

endmodule

// File: rtl/legv8_multicycle_sequencer.sv
// LEGv8 multicycle control FSM: IF, variable-length EX, sticky HALT.
// Optional MUL decode is enabled by defining LEGV8_SEQ_MUL_EN.
module legv8_multicycle_sequencer
  import legv8_ctrl_pkg::*;
#(
  parameter int CW_LEN        = 34,
  parameter int NUM_EX_STATES = 4,
  parameter int MUL_LATENCY   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic [4:0]        status,
  input  logic              mem_ready,
  output logic [CW_LEN-1:0] control_word,
  output logic [2:0]        const_sel,
  output logic [2:0]        ex_step,
  output logic              in_fetch,
  output logic              halted
);

  state_e          r_state, w_state_nxt;
  logic [2:0]      r_step, w_step_nxt;
  cls_e            w_dec_cls;
  logic [3:0]      w_dec_steps;
  logic [3:0]      w_last_idx;
  logic            w_dec_ill;
  cw_t             w_dec_cw;
  logic [2:0]      w_dec_cs;
  logic            w_wait, w_last;
  logic [CW_W-1:0] w_word;
  logic [2:0]      w_cs;

  legv8_class_decode #(
    .NUM_EX_STATES (NUM_EX_STATES),
    .MUL_LATENCY   (MUL_LATENCY)
  ) u_dec (
    .i_instr     (instruction),
    .i_status    (status),
    .i_step      (r_step),
    .o_cls       (w_dec_cls),
    .o_steps     (w_dec_steps),
    .o_ill       (w_dec_ill),
    .o_cw        (w_dec_cw),
    .o_const_sel (w_dec_cs)
  );

  assign w_wait     = (w_dec_cls == CLS_MEM) && !mem_ready;
  assign w_last_idx = w_dec_steps - 4'd1;
  assign w_last     = ({1'b0, r_step} == w_last_idx);

  // state and step register; reset aborts straight back to IF
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IF;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // next state and the control word for the current cycle
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_word      = '0;
    w_cs        = CS_ZF12;
    unique case (r_state)
      ST_IF: begin
        w_word[CW_MR]      = 1'b1;
        w_word[CW_IL]      = mem_ready;
        w_word[CW_PS +: 2] = mem_ready ? PS_INC : PS_HOLD;
        w_step_nxt         = '0;
        if (mem_ready) begin
          w_state_nxt = ST_EX;
        end
      end
      ST_EX: begin
        if (w_dec_ill) begin
          w_state_nxt = ST_HALT;
          w_step_nxt  = '0;
        end else begin
          w_word = w_dec_cw;
          w_cs   = w_dec_cs;
          if (w_wait) begin
            w_word[CW_RW]      = 1'b0;
            w_word[CW_PS +: 2] = PS_HOLD;
          end else if (w_last) begin
            w_state_nxt = ST_IF;
            w_step_nxt  = '0;
          end else begin
            w_step_nxt = r_step + 3'd1;
          end
        end
      end
      ST_HALT: begin
        w_step_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_HALT;
        w_step_nxt  = '0;
      end
    endcase
  end

  assign control_word = reset ? CW_LEN'(w_word) : '0;
  assign const_sel    = reset ? w_cs : 3'd0;
  assign ex_step      = (reset && r_state == ST_EX) ? r_step : 3'd0;
  assign in_fetch     = reset && (r_state == ST_IF);
  assign halted       = reset && (r_state == ST_HALT);

endmodule

// File: tb/tb_legv8_multicycle_sequencer.sv
// Bench for legv8_multicycle_sequencer: per-cycle expectation table
// fed through a scoreboard queue, plus reset/halt/MUL sequences.
module tb_legv8_multicycle_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic        mem_ready;
  logic [33:0] control_word;
  logic [2:0]  const_sel;
  logic [2:0]  ex_step;
  logic        in_fetch;
  logic        halted;

  legv8_multicycle_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .status       (status),
    .mem_ready    (mem_ready),
    .control_word (control_word),
    .const_sel    (const_sel),
    .ex_step      (ex_step),
    .in_fetch     (in_fetch),
    .halted       (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [33:0] M_SL   = 34'd1 << 33;
  localparam logic [33:0] M_IL   = 34'd1 << 32;
  localparam logic [33:0] M_PCS  = 34'd1 << 28;
  localparam logic [33:0] M_BSEL = 34'd1 << 27;
  localparam logic [33:0] M_MR   = 34'd1 << 26;
  localparam logic [33:0] M_MW   = 34'd1 << 25;
  localparam logic [33:0] M_RW   = 34'd1 << 22;
  localparam logic [33:0] M_PS   = 34'd3 << 20;
  localparam logic [33:0] PS01   = 34'd1 << 20;
  localparam logic [33:0] PS10   = 34'd2 << 20;
  localparam logic [33:0] PS11   = 34'd3 << 20;
  localparam logic [33:0] M_SB   = 34'd31 << 10;
  localparam logic [33:0] M_SA   = 34'd31 << 5;
  localparam logic [33:0] M_DA   = 34'd31;
  localparam logic [33:0] M_EN   = M_IL | M_MW | M_RW | M_PS | M_MR;
  localparam logic [33:0] M_ALL  = {34{1'b1}};

  localparam logic [31:0] ADDI = 32'h91001441;
  localparam logic [31:0] CBZ  = 32'hB4000043;
  localparam logic [31:0] LDUR = 32'hF8408041;
  localparam logic [31:0] STUR = 32'hF8000041;
  localparam logic [31:0] BL   = 32'h94000004;
  localparam logic [31:0] BEQ  = 32'h54000040;
  localparam logic [31:0] ADDR = 32'h8B030041;
  localparam logic [31:0] BRR  = 32'hD61F03C0;
  localparam logic [31:0] MUL  = 32'h9B037C41;
  localparam logic [31:0] ILL  = 32'h00000000;

  typedef struct {
    string       tag;
    logic [31:0] ins;
    logic [4:0]  st;
    logic        mr;
    logic [33:0] mask;
    logic [33:0] val;
    logic        csc;
    logic [2:0]  cs;
    logic [2:0]  step;
    logic        f;
    logic        h;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t row(
    input string tag, input logic [31:0] ins, input logic [4:0] st,
    input logic mr, input logic [33:0] mask, input logic [33:0] val,
    input logic csc, input logic [2:0] cs, input logic [2:0] step,
    input logic f, input logic h);
    vec_t v;
    v.tag = tag; v.ins = ins; v.st = st; v.mr = mr;
    v.mask = mask; v.val = val; v.csc = csc; v.cs = cs;
    v.step = step; v.f = f; v.h = h;
    return v;
  endfunction

  function automatic vec_t ifr(input string tag, input logic [31:0] ins,
                               input logic mr);
    return row(tag, ins, 5'd0, mr, M_EN | M_SL,
               mr ? (M_MR | M_IL | PS01) : M_MR,
               1'b1, 3'd0, 3'd0, 1'b1, 1'b0);
  endfunction

  // compare whatever the driver expected for this cycle
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk({e.tag, "_cw"}, 64'(control_word & e.mask),
          64'(e.val & e.mask));
      if (e.csc) chk({e.tag, "_cs"}, 64'(const_sel), 64'(e.cs));
      chk({e.tag, "_step"}, 64'(ex_step), 64'(e.step));
      chk({e.tag, "_fetch"}, 64'(in_fetch), 64'(e.f));
      chk({e.tag, "_halt"}, 64'(halted), 64'(e.h));
    end
  end

  task automatic drive(input vec_t v);
    instruction = v.ins;
    status      = v.st;
    mem_ready   = v.mr;
    sb.push_back(v);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string nm);
    #1 reset = 1'b0;
    #1;
    chk({nm, "_rst_cw"}, 64'(control_word), 64'd0);
    chk({nm, "_rst_cs"}, 64'(const_sel), 64'd0);
    chk({nm, "_rst_step"}, 64'(ex_step), 64'd0);
    chk({nm, "_rst_fetch"}, 64'(in_fetch), 64'd0);
    chk({nm, "_rst_halt"}, 64'(halted), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    instruction = ILL;
    status      = 5'd0;
    mem_ready   = 1'b0;
    #2;
    chk("init_cw", 64'(control_word), 64'd0);
    chk("init_cs", 64'(const_sel), 64'd0);
    chk("init_step", 64'(ex_step), 64'd0);
    chk("init_halt", 64'(halted), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    tbl.push_back(ifr("addi_if", ADDI, 1'b1));
    tbl.push_back(row("addi_ex0", ADDI, 5'd0, 1'b1,
      M_EN | M_SA | M_DA | M_BSEL,
      M_RW | M_BSEL | (34'd2 << 5) | 34'd1,
      1'b1, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(ifr("cbz_if", CBZ, 1'b1));
    tbl.push_back(row("cbz_t", CBZ, 5'b00001, 1'b1, M_EN | M_PCS,
      PS11 | M_PCS, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0));
    tbl.push_back(ifr("cbz_if2", CBZ, 1'b1));
    tbl.push_back(row("cbz_nt", CBZ, 5'b00000, 1'b1, M_EN | M_PCS,
      M_PCS, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0));
    tbl.push_back(ifr("if_stall", LDUR, 1'b0));
    tbl.push_back(ifr("ldur_if", LDUR, 1'b1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(row("ldur_wait", LDUR, 5'd0, 1'b0, M_EN | M_BSEL,
        M_MR | M_BSEL, 1'b1, 3'd6, 3'd0, 1'b0, 1'b0));
    tbl.push_back(row("ldur_rdy", LDUR, 5'd0, 1'b1, M_EN | M_BSEL,
      M_MR | M_RW | M_BSEL, 1'b1, 3'd6, 3'd0, 1'b0, 1'b0));
    tbl.push_back(ifr("bl_if", BL, 1'b1));
    tbl.push_back(row("bl_ex0", BL, 5'd0, 1'b1, M_EN | M_DA,
      M_RW | 34'd30, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(row("bl_ex1", BL, 5'd0, 1'b1, M_EN | M_PCS,
      PS11 | M_PCS, 1'b1, 3'd4, 3'd1, 1'b0, 1'b0));
    tbl.push_back(ifr("stur_if", STUR, 1'b1));
    tbl.push_back(row("stur_wait", STUR, 5'd0, 1'b0, M_EN,
      M_MW, 1'b1, 3'd6, 3'd0, 1'b0, 1'b0));
    tbl.push_back(row("stur_rdy", STUR, 5'd0, 1'b1, M_EN,
      M_MW, 1'b1, 3'd6, 3'd0, 1'b0, 1'b0));
    tbl.push_back(ifr("beq_if", BEQ, 1'b1));
    tbl.push_back(row("beq_t", BEQ, 5'b00010, 1'b1, M_EN | M_PCS,
      PS11 | M_PCS, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0));
    tbl.push_back(ifr("beq_if2", BEQ, 1'b1));
    tbl.push_back(row("beq_nt", BEQ, 5'b11101, 1'b1, M_EN | M_PCS,
      M_PCS, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0));
    tbl.push_back(ifr("addr_if", ADDR, 1'b1));
    tbl.push_back(row("addr_ex0", ADDR, 5'd0, 1'b1,
      M_EN | M_SB | M_SA | M_DA | M_BSEL,
      M_RW | (34'd3 << 10) | (34'd2 << 5) | 34'd1,
      1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(ifr("br_if", BRR, 1'b1));
    tbl.push_back(row("br_ex0", BRR, 5'd0, 1'b1, M_EN | M_SA,
      PS10 | (34'd30 << 5), 1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(ifr("tail_if", ILL, 1'b0));

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

    drive(ifr("ill_if", ILL, 1'b1));
    drive(row("ill_ex0", ILL, 5'd0, 1'b1, M_ALL, 34'd0,
              1'b1, 3'd0, 3'd0, 1'b0, 1'b0));
    for (int k = 0; k < 10; k++)
      drive(row("halt", ILL, 5'($urandom_range(31)), 1'(k % 2),
                M_ALL, 34'd0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1));
    do_reset("halt");

    drive(ifr("mul_if", MUL, 1'b1));
`ifdef LEGV8_SEQ_MUL_EN
    drive(row("mul_s0", MUL, 5'd0, 1'b1, M_EN, 34'd0,
              1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
    drive(row("mul_s1", MUL, 5'd0, 1'b1, M_EN, 34'd0,
              1'b0, 3'd0, 3'd1, 1'b0, 1'b0));
    drive(row("mul_s2", MUL, 5'd0, 1'b1, M_EN, M_RW,
              1'b0, 3'd0, 3'd2, 1'b0, 1'b0));
    drive(ifr("mul_if2", MUL, 1'b1));
    drive(row("mul_r0", MUL, 5'd0, 1'b1, M_EN, 34'd0,
              1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
    chk("mul_r1_step", 64'(ex_step), 64'd1);
    do_reset("mul_s1");
`else
    drive(row("mul_ill", MUL, 5'd0, 1'b1, M_ALL, 34'd0,
              1'b1, 3'd0, 3'd0, 1'b0, 1'b0));
    drive(row("mul_halt", MUL, 5'd0, 1'b1, M_ALL, 34'd0,
              1'b1, 3'd0, 3'd0, 1'b0, 1'b1));
    do_reset("mul_halt");
`endif

    drive(ifr("rst_if", LDUR, 1'b1));
    mem_ready = 1'b0;
    #1;
    chk("ldur_pre_rst_mr", 64'(control_word[26]), 64'd1);
    do_reset("ldur");
    drive(ifr("post_rst_if", ILL, 1'b0));

    @(negedge clock);
    #1;
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
